// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory-dump UART.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN (appends an XOR checksum frame).
package mem_dump_pkg;

  localparam int FRAME_BITS     = 10;  // start + 8 data + stop
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_NEXT,
    S_CHK,
    S_DONE
  } state_t;

  // XOR of the four bytes of a word; equals the XOR of the bytes as they go out.
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

endpackage

// File: rtl/mem_dump_uart_if.sv
// Control and secondary-read-port bundle of the memory-dump UART.
// Handshake: start is a one-cycle request accepted only while busy is low;
// busy rises the cycle after an accepted start and falls in the cycle done
// pulses; base_addr/word_count are sampled only on the accepted start.
// The memory side has no handshake: DataRd_2 is valid a fixed READ_LATENCY
// cycles after address_2 is stable.
interface mem_dump_uart_if;
  logic        start;
  logic [31:0] base_addr;
  logic [11:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] address_2;
  logic [31:0] DataRd_2;

  // master: the requester plus the memory model
  modport master (
    output start, base_addr, word_count, DataRd_2,
    input  busy, done, address_2
  );

  // slave: the dump engine
  modport slave (
    input  start, base_addr, word_count, DataRd_2,
    output busy, done, address_2
  );
endinterface

// File: rtl/mem_dump_uart_tx_byte.sv
// 8N1 byte transmitter: shift register, baud counter and bit counter.
// ready is high when idle and also during the final cycle of the stop bit,
// so a load in that cycle starts the next frame back to back.
module uart_tx_byte
  import mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic                  active_q, active_d;
  logic                  bit_end;
  logic                  last_bit;

  assign bit_end  = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_q == 4'(FRAME_BITS - 1));
  assign ready    = !active_q || (bit_end && last_bit);
  // Idle shift contents are all ones, so the line sits high without a mux.
  assign tx       = shift_q[0];

  // Next-state: load a frame, or advance baud/bit counters while active.
  always_comb begin
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (load && ready) begin
      shift_d  = {1'b1, byte_in, 1'b0};
      baud_d   = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d  = '0;
        shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
        bit_d   = bit_q + 4'd1;
        if (last_bit) active_d = 1'b0;
      end else begin
        baud_d = baud_q + CW'(1);
      end
    end
  end

  // State registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/mem_dump_uart.sv
// Dumps word_count words from the secondary read port over a UART, LSB first.
// Optional: define MEM_DUMP_CHECKSUM_EN to append an XOR-of-all-bytes frame.
module mem_dump_uart
  import mem_dump_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_dump_uart_if.slave        bus,
  output logic                  tx,
  output state_t                dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [1:0] WAIT_LAST =
    (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [11:0] remain_q, remain_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  wait_q, wait_d;
  logic        capture;
  logic        tx_load;
  logic [7:0]  tx_byte;
  logic        tx_ready;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
  logic        chk_sent_q, chk_sent_d;
`endif

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tx_load),
    .byte_in (tx_byte),
    .tx      (tx),
    .ready   (tx_ready)
  );

  assign bus.address_2 = addr_q;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign dbg_state     = state_q;

  // FSM next-state, address/word counters and transmitter feed.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    wait_d     = wait_q;
    capture    = 1'b0;
    tx_load    = 1'b0;
    tx_byte    = word_q[7:0];
`ifdef MEM_DUMP_CHECKSUM_EN
    chk_d      = chk_q;
    chk_sent_d = chk_sent_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d     = bus.base_addr & 32'hFFFF_FFFC;
          remain_d   = bus.word_count;
          byte_idx_d = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
          chk_d      = '0;
          chk_sent_d = 1'b0;
`endif
          state_d    = (bus.word_count == 12'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        wait_d = '0;
        if (READ_LATENCY == 0) capture = 1'b1;
        else                   state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) capture = 1'b1;
        else                     wait_d  = wait_q + 2'd1;
      end
      S_SEND: begin
        // byte_idx_q names the byte currently in the transmitter.
        if (tx_ready) begin
          if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
            state_d = S_NEXT;
          end else begin
            tx_load    = 1'b1;
            tx_byte    = word_q[7:0];
            word_d     = word_q >> 8;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_NEXT: begin
        remain_d = remain_q - 12'd1;
        if (remain_q != 12'd1) begin
          // Address only moves when another fetch follows, so it holds afterwards.
          addr_d  = addr_q + 32'd4;
          state_d = S_FETCH;
        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CHK: begin
        if (!chk_sent_q) begin
          tx_load    = 1'b1;
          tx_byte    = chk_q;
          chk_sent_d = 1'b1;
        end else if (tx_ready) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read data is valid: start byte 0 immediately and keep the rest.
    if (capture) begin
      tx_load    = 1'b1;
      tx_byte    = bus.DataRd_2[7:0];
      word_d     = bus.DataRd_2 >> 8;
      byte_idx_d = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      chk_d      = chk_q ^ xor_bytes(bus.DataRd_2);
`endif
      state_d    = S_SEND;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      wait_q     <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      chk_q      <= '0;
      chk_sent_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      wait_q     <= wait_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      chk_q      <= chk_d;
      chk_sent_q <= chk_sent_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_dump_uart.sv
// Bench for mem_dump_uart: expected bytes/done cycles queued at issue time,
// frame decoder and done monitor compare independently.
module tb_mem_dump_uart;
  import mem_dump_pkg::*;

  localparam int CPB = 16;
  localparam int RL  = 1;
  localparam int WORD_CYCLES = 40 * CPB + RL + 2;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   tx;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_dump_uart_if bus ();

  mem_dump_uart #(.CLK_FREQ(16), .BAUD(1), .READ_LATENCY(RL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .tx        (tx),
    .dbg_state (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [bit [29:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a[31:2])) return mem_arr[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h9E37_79B9;
  endfunction

  always @(posedge clk) bus.DataRd_2 <= mem_rd(bus.address_2);

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         exp_done_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: byte stream and done cycle from the behavioural description.
  task automatic expect_dump(input logic [31:0] base, input int count, input int k);
    logic [31:0] a;
    logic [31:0] w;
    logic [7:0]  cs;
    int          extra;
    a = {base[31:2], 2'b00};
    cs = 8'h00;
    extra = 0;
    for (int i = 0; i < count; i++) begin
      w = mem_rd(a);
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
      a = a + 32'd4;
    end
    if (CHK_EN && count > 0) begin
      exp_q.push_back(cs);
      extra = 10 * CPB + 1;
    end
    exp_done_q.push_back(k + count * WORD_CYCLES + 1 + extra);
  endtask

  // ---------------- driver ----------------
  // Returns at the sampling point of cycle 1.
  task automatic issue(input logic [31:0] base, input int count, output int k);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = 12'(count);
    k = cyc;
    expect_dump(base, count, k);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.base_addr  = $urandom;
    bus.word_count = 12'($urandom);
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_done_q.size() == 0) break;
      @(negedge clk);
    end
    check("done_timeout", 32'(exp_done_q.size()), 32'd0);
    check("frames_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitors ----------------
  initial begin : decoder
    logic [7:0] data;
    logic       aborted;
    logic       ok_start;
    logic       ok_stop;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        data = 8'h00;
        ok_start = 1'b0;
        ok_stop = 1'b0;
        for (int t = 1; t <= 9 * CPB + CPB / 2; t++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
          if (t == CPB / 2) ok_start = (tx === 1'b0);
          else if (t == 9 * CPB + CPB / 2) ok_stop = (tx === 1'b1);
          else if (t > CPB && ((t - CPB / 2) % CPB) == 0) data[(t - CPB / 2) / CPB - 1] = tx;
        end
        if (!aborted) begin
          check("start_bit", 32'(ok_start), 32'd1);
          check("stop_bit", 32'(ok_stop), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_unexpected actual=%h expected=none (cycle %0d)", data, cyc);
          end else begin
            check("frame_byte", 32'(data), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          check("done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
        end
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int          k;
    logic [31:0] base;
    int          count;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_addr", bus.address_2, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word
    mem_arr[30'h4] = 32'hA1B2_C3D4;
    issue(32'h10, 1, k);
    check("single_addr_c1", bus.address_2, 32'h10);
    check("single_busy_c1", 32'(bus.busy), 32'd1);
    wait_done(2000);

    // Empty dump
    repeat (3) @(negedge clk);
    issue(32'h40, 0, k);
    check("empty_busy_c1", 32'(bus.busy), 32'd0);
    check("empty_tx_c1", 32'(tx), 32'd1);
    @(negedge clk);
    check("empty_busy_c2", 32'(bus.busy), 32'd0);
    wait_done(10);
    repeat (40) @(negedge clk);
    check("empty_tx_after", 32'(tx), 32'd1);

    // Wrap-around
    issue(32'hFFFF_FFFE, 2, k);
    check("wrap_addr_w0", bus.address_2, 32'hFFFF_FFFC);
    repeat (WORD_CYCLES - 1) @(negedge clk);
    check("wrap_addr_hold", bus.address_2, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_addr_w1", bus.address_2, 32'h0000_0000);
    wait_done(3000);

    // Busy protection: second start during byte 2
    mem_arr[30'h40] = $urandom;
    issue(32'h100, 1, k);
    repeat (2 + 2 * 10 * CPB + 40) @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = 32'h800;
    bus.word_count = 12'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(2000);
    repeat (300) @(negedge clk);
    check("busy_prot_idle", 32'(dbg_state), 32'(S_IDLE));

`ifdef MEM_DUMP_CHECKSUM_EN
    // Checksum frame
    mem_arr[30'h80] = 32'h0102_0304;
    mem_arr[30'h81] = 32'h1020_3040;
    issue(32'h200, 2, k);
    wait_done(3000);
`endif

    // Randomized dumps
    for (int n = 0; n < 4; n++) begin
      base  = $urandom;
      count = $urandom_range(1, 3);
      for (int i = 0; i < count; i++) begin
        logic [31:0] a;
        a = {base[31:2], 2'b00} + 32'(4 * i);
        mem_arr[a[31:2]] = $urandom;
      end
      repeat ($urandom_range(1, 20)) @(negedge clk);
      issue(base, count, k);
      check("rand_addr_c1", bus.address_2, {base[31:2], 2'b00});
      wait_done(count * WORD_CYCLES + 400);
    end

    // Reset mid-frame
    issue(32'h300, 2, k);
    repeat (39) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    #1;
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_addr", bus.address_2, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    check("rstmid_busy_after", 32'(bus.busy), 32'd0);
    check("rstmid_tx_after", 32'(tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
